if_id_pipeline_register: RTL and testbench

- IF/ID stage boundary register of the 5-stage MIPS pipeline.
- Captures the fetched instruction and its PC+4 (next_PC) from the IF stage and presents them to the ID stage one clock later.
- Loads only when the instruction cache reports a hit and the hazard unit is not stalling.
- Supports flush (bubble insertion) for taken branches and jumps.

---
 rtl/if_id_pipeline_register_if.sv | 40 ++++
 rtl/if_id_pipeline_register.sv | 50 +++++
 tb/tb_if_id_pipeline_register.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/if_id_pipeline_register_if.sv
// IF/ID boundary bus: fetch-side inputs to the pipeline register and the
// registered instruction/PC+4 presented to the ID stage.
interface if_id_pipeline_register_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] next_PC;
  logic                  hit;
  logic                  stall;
  logic                  flush;

  logic [DATA_WIDTH-1:0] instruction_output;
  logic [DATA_WIDTH-1:0] next_PC_output;
  logic                  valid_output;

  // The IF stage / hazard unit side drives the controls and fetched data
  modport master (
    output instruction,
    output next_PC,
    output hit,
    output stall,
    output flush,
    input  instruction_output,
    input  next_PC_output,
    input  valid_output
  );

  modport slave (
    input  instruction,
    input  next_PC,
    input  hit,
    input  stall,
    input  flush,
    output instruction_output,
    output next_PC_output,
    output valid_output
  );

endinterface

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: captures instruction and PC+4 on a cache hit,
// holds on stall or miss, and inserts a bubble on flush.
module if_id_pipeline_register #(
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTRUCTION = '0
) (
  input logic                      clock,
  input logic                      reset_n,
  if_id_pipeline_register_if.slave bus
);

  logic [DATA_WIDTH-1:0] instruction_reg;
  logic [DATA_WIDTH-1:0] next_pc_reg;
  logic                  valid_reg;

  logic                  do_bubble;
  logic                  do_load;

  // Flush outranks stall and miss so a squashed instruction never survives a hold
  always_comb begin
    do_bubble = 1'b0;
    do_load   = 1'b0;
    if (bus.flush) begin
      do_bubble = 1'b1;
    end else if (!bus.stall && bus.hit) begin
      do_load = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instruction_reg <= NOP_INSTRUCTION;
      next_pc_reg     <= '0;
      valid_reg       <= 1'b0;
    end else if (do_bubble) begin
      instruction_reg <= NOP_INSTRUCTION;
      next_pc_reg     <= '0;
      valid_reg       <= 1'b0;
    end else if (do_load) begin
      instruction_reg <= bus.instruction;
      next_pc_reg     <= bus.next_PC;
      valid_reg       <= 1'b1;
    end
  end

  assign bus.instruction_output = instruction_reg;
  assign bus.next_PC_output     = next_pc_reg;
  assign bus.valid_output       = valid_reg;

endmodule

// File: tb/tb_if_id_pipeline_register.sv
// Scoreboard bench for the IF/ID pipeline register: directed test-plan
// sequence followed by randomized traffic against a rule-level model.
module tb_if_id_pipeline_register;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } reg_state_t;

  localparam reg_state_t RESET_STATE = '{instr: 32'h0, pc: 32'h0, valid: 1'b0};

  logic clock;
  logic reset_n;

  if_id_pipeline_register_if #(.DATA_WIDTH(32)) bus ();

  if_id_pipeline_register #(
    .DATA_WIDTH(32),
    .NOP_INSTRUCTION(32'h00000000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  reg_state_t exp_q[$];
  reg_state_t cur_state;
  int         check_count = 0;
  int         pass_count  = 0;

  function automatic reg_state_t dut_state();
    reg_state_t s;
    s.instr = bus.instruction_output;
    s.pc    = bus.next_PC_output;
    s.valid = bus.valid_output;
    return s;
  endfunction

  // What the register should hold after one edge, from the stage-boundary rules
  function automatic reg_state_t next_contents(reg_state_t cur, logic [31:0] instr,
                                               logic [31:0] pc, logic hit,
                                               logic stall, logic flush);
    reg_state_t loaded;
    loaded = '{instr: instr, pc: pc, valid: 1'b1};
    if (flush) return RESET_STATE;
    if (stall || !hit) return cur;
    return loaded;
  endfunction

  task automatic checkOutput(input string name, input reg_state_t exp_s, input reg_state_t act_s);
    check_count++;
    if (exp_s === act_s) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got instr=%h pc=%h valid=%b, required instr=%h pc=%h valid=%b",
               name, act_s.instr, act_s.pc, act_s.valid, exp_s.instr, exp_s.pc, exp_s.valid);
    end
  endtask

  // Drive one cycle of inputs just after an edge and queue what the next edge must produce
  task automatic applyStimulus(input logic rst_level, input logic [31:0] instr,
                               input logic [31:0] pc, input logic hit, input logic stall,
                               input logic flush, input logic pulse, input logic mid_check);
    reg_state_t nxt;
    @(posedge clock);
    #2;
    reset_n         = rst_level;
    bus.instruction = instr;
    bus.next_PC     = pc;
    bus.hit         = hit;
    bus.stall       = stall;
    bus.flush       = flush;
    if (!rst_level) cur_state = RESET_STATE;
    if (mid_check) begin
      #1;
      checkOutput("no_comb_path", cur_state, dut_state());
    end
    if (pulse && rst_level) begin
      #1 reset_n = 1'b0;
      #1 checkOutput("async_reset_mid_cycle", RESET_STATE, dut_state());
      #1 reset_n = 1'b1;
      cur_state = RESET_STATE;
    end
    if (!rst_level) nxt = RESET_STATE;
    else            nxt = next_contents(cur_state, instr, pc, hit, stall, flush);
    exp_q.push_back(nxt);
    cur_state = nxt;
  endtask

  // Monitor: every edge the register presents new contents; compare against the queue head
  initial begin
    reg_state_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("scoreboard", e, dut_state());
      end
    end
  end

  initial begin
    logic        r_rst;
    logic        r_hit;
    logic        r_stall;
    logic        r_flush;
    logic        r_pulse;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    int          drain_cycles;

    reset_n         = 1'b0;
    bus.instruction = 32'hFFFFFFFF;
    bus.next_PC     = 32'h0;
    bus.hit         = 1'b1;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    cur_state       = RESET_STATE;
    #1;
    checkOutput("reset_immediate", RESET_STATE, dut_state());

    // Reset held across edges, then release loads the waiting instruction
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h8C220004, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 32'h12345678, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h12345678, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'hDEADBEEF, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hCAFEF00D, 32'h14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h24420001, 32'h18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h0BADF00D, 32'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h00851020, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'hAAAA5555, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h11111111, 32'h28, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h22222222, 32'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      r_rst   = ($urandom_range(0, 49) != 0);
      r_hit   = ($urandom_range(0, 3) != 0);
      r_stall = ($urandom_range(0, 4) == 0);
      r_flush = ($urandom_range(0, 9) == 0);
      r_pulse = ($urandom_range(0, 39) == 0);
      r_instr = $urandom;
      r_pc    = $urandom;
      applyStimulus(r_rst, r_instr, r_pc, r_hit, r_stall, r_flush, r_pulse, 1'b1);
    end

    drain_cycles = 0;
    while (exp_q.size() > 0 && drain_cycles < 5) begin
      @(posedge clock);
      drain_cycles++;
    end
    #3;
    check_count++;
    if (exp_q.size() == 0) pass_count++;
    else $display("[TB] FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
